// File: rtl/seg_disp_sched_if.sv
// Bundle between display sources, the scheduler and the 7-segment multiplexer.
// Master drives sources and controls; slave is the scheduler.
interface seg_disp_sched_if;
    logic [63:0] src_number;
    logic [15:0] src_dot;
    logic [3:0]  src_valid;
    logic [3:0]  urgent;
    logic        auto_en;
    logic        btn_next;
    logic [15:0] number;
    logic [3:0]  dot;
    logic [1:0]  cur_src;
    logic        urgent_act;
    logic        scan_en;

    modport master (
        output src_number, src_dot, src_valid, urgent,
        output auto_en, btn_next,
        input  number, dot, cur_src, urgent_act, scan_en
    );

    modport slave (
        input  src_number, src_dot, src_valid, urgent,
        input  auto_en, btn_next,
        output number, dot, cur_src, urgent_act, scan_en
    );
endinterface

// File: rtl/seg_disp_sched.sv
// Picks which of four sources the 7-segment display shows:
// timed rotation, manual stepping and urgent one-shot overrides.
module seg_disp_sched #(
    parameter int TICK_DIV     = 50000,
    parameter int HOLD_TICKS   = 1000,
    parameter int URGENT_TICKS = 2000,
    parameter int SCAN_DIV     = 1000
) (
    input  logic             clk,
    input  logic             nrst,
    seg_disp_sched_if.slave  bus
);
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int HW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
    localparam int UW = (URGENT_TICKS > 1) ? $clog2(URGENT_TICKS) : 1;
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    typedef enum logic [1:0] {ROTATE, MANUAL, URGENT} state_t;

    state_t        state, n_state, mode;
    logic [TW-1:0] tick_cnt;
    logic [SW-1:0] scan_cnt;
    logic [HW-1:0] hold_cnt, n_hold;
    logic [UW-1:0] urg_cnt, n_urg;
    logic [1:0]    cur_r, n_src, saved, n_saved, win;
    logic [2:0]    bsync;
    logic [3:0]    urg_prev, urg_edge;
    logic          tick, step, show;
    logic [15:0]   num_r, n_num;
    logic [3:0]    dot_r, n_dot;
    logic          act_r, scan_r;

    function automatic logic [1:0] adv(input logic [1:0] s,
                                       input logic [3:0] v);
        logic [1:0] r;
        r = s;
        // descending so the nearest valid successor wins
        for (int k = 3; k >= 1; k--)
            if (v[s + 2'(k)]) r = s + 2'(k);
        return r;
    endfunction

    assign tick     = (tick_cnt == TW'(TICK_DIV - 1));
    assign step     = bsync[1] & ~bsync[2];
    assign urg_edge = bus.urgent & ~urg_prev;
    assign mode     = bus.auto_en ? ROTATE : MANUAL;

    always_comb begin
        win = 2'd0;
        priority case (1'b1)
            urg_edge[0]: win = 2'd0;
            urg_edge[1]: win = 2'd1;
            urg_edge[2]: win = 2'd2;
            urg_edge[3]: win = 2'd3;
            default:     win = 2'd0;
        endcase
    end

    always_comb begin
        n_state = state;
        n_src   = cur_r;
        n_hold  = hold_cnt;
        n_urg   = urg_cnt;
        n_saved = saved;
        if (|urg_edge) begin
            n_state = URGENT;
            n_src   = win;
            n_urg   = '0;
            n_hold  = '0;
            if (state != URGENT) n_saved = cur_r;
        end else if (state == URGENT) begin
            if (tick) begin
                if (urg_cnt == UW'(URGENT_TICKS - 1)) begin
                    n_state = mode;
                    n_src   = saved;
                    n_hold  = '0;
                    n_urg   = '0;
                end else begin
                    n_urg = urg_cnt + UW'(1);
                end
            end
        end else if (step) begin
            n_state = mode;
            n_src   = adv(cur_r, bus.src_valid);
            n_hold  = '0;
        end else if (state != mode) begin
            n_state = mode;
            n_hold  = '0;
        end else if (state == ROTATE && tick) begin
            if (hold_cnt == HW'(HOLD_TICKS - 1)) begin
                n_src  = adv(cur_r, bus.src_valid);
                n_hold = '0;
            end else begin
                n_hold = hold_cnt + HW'(1);
            end
        end
        // an override is shown even if its source is not valid
        show  = (n_state == URGENT) || bus.src_valid[n_src];
        n_num = show ? bus.src_number[{n_src, 4'b0} +: 16] : 16'h0;
        n_dot = show ? bus.src_dot[{n_src, 2'b0} +: 4] : 4'h0;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            tick_cnt <= '0;
            scan_cnt <= '0;
            scan_r   <= 1'b0;
            bsync    <= '0;
            urg_prev <= '0;
        end else begin
            tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
            if (scan_cnt == SW'(SCAN_DIV - 1)) scan_cnt <= '0;
            else scan_cnt <= scan_cnt + SW'(1);
            scan_r   <= (scan_cnt == SW'(SCAN_DIV - 1));
            bsync    <= {bsync[1:0], bus.btn_next};
            urg_prev <= bus.urgent;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state    <= ROTATE;
            cur_r    <= 2'd0;
            saved    <= 2'd0;
            hold_cnt <= '0;
            urg_cnt  <= '0;
            num_r    <= 16'h0;
            dot_r    <= 4'h0;
            act_r    <= 1'b0;
        end else begin
            state    <= n_state;
            cur_r    <= n_src;
            saved    <= n_saved;
            hold_cnt <= n_hold;
            urg_cnt  <= n_urg;
            num_r    <= n_num;
            dot_r    <= n_dot;
            act_r    <= (n_state == URGENT);
        end
    end

    assign bus.number     = num_r;
    assign bus.dot        = dot_r;
    assign bus.cur_src    = cur_r;
    assign bus.urgent_act = act_r;
    assign bus.scan_en    = scan_r;
endmodule

// File: tb/tb_seg_disp_sched.sv
// Bench for seg_disp_sched: directed table, corner sequences and
// random traffic against a tick-counting reference model.
module tb_seg_disp_sched;
    localparam int TD = 4;
    localparam int HT = 3;
    localparam int UT = 2;
    localparam int SD = 2;

    logic clk = 1'b0;
    logic nrst = 1'b0;
    seg_disp_sched_if bus();

    seg_disp_sched #(
        .TICK_DIV(TD), .HOLD_TICKS(HT),
        .URGENT_TICKS(UT), .SCAN_DIV(SD)
    ) dut (
        .clk(clk), .nrst(nrst), .bus(bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    int unsigned k;
    bit          m_urg, m_auto;
    logic [1:0]  m_src, m_saved;
    int          m_hold, m_uticks;
    bit [2:0]    bh;
    logic [3:0]  uprev;
    logic [15:0] e_num;
    logic [3:0]  e_dot;
    bit          e_scan;

    typedef struct {
        logic [3:0]  valid;
        bit          auto_en;
        bit          btn;
        logic [3:0]  urg;
        int          n;
        logic [1:0]  cur;
        logic [15:0] num;
        bit          act;
    } vec_t;

    vec_t tbl[25];

    function automatic vec_t mk(logic [3:0] v, bit a, bit b,
                                logic [3:0] u, int n, logic [1:0] c,
                                logic [15:0] num, bit act);
        vec_t r;
        r.valid = v; r.auto_en = a; r.btn = b; r.urg = u;
        r.n = n; r.cur = c; r.num = num; r.act = act;
        return r;
    endfunction

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at t=%0t edge=%0d: got %h want %h",
                     nm, $time, k, act, exp);
        end
    endtask

    function automatic logic [1:0] nextv(logic [1:0] s, logic [3:0] v);
        for (int d = 1; d < 4; d++)
            if (v[(int'(s) + d) % 4]) return 2'((int'(s) + d) % 4);
        return s;
    endfunction

    task automatic model_reset();
        k = 0; m_urg = 0; m_auto = 1; m_src = 0; m_saved = 0;
        m_hold = 0; m_uticks = 0; bh = 0; uprev = 0;
        e_num = 0; e_dot = 0; e_scan = 0;
    endtask

    // advance the model by one clock using the inputs now applied
    task automatic model_edge();
        bit tick, stp, show;
        logic [3:0] ue;
        logic [1:0] w;
        k++;
        tick = (k % TD) == 0;
        stp = bh[1] && !bh[2];
        bh = {bh[1:0], bus.btn_next};
        ue = bus.urgent & ~uprev;
        uprev = bus.urgent;
        w = 0;
        for (int i = 3; i >= 0; i--) if (ue[i]) w = 2'(i);
        if (ue != 0) begin
            if (!m_urg) m_saved = m_src;
            m_urg = 1; m_src = w; m_uticks = 0;
        end else if (m_urg) begin
            if (tick) begin
                m_uticks++;
                if (m_uticks == UT) begin
                    m_urg = 0; m_src = m_saved;
                    m_hold = 0; m_auto = bus.auto_en;
                end
            end
        end else if (stp) begin
            m_src = nextv(m_src, bus.src_valid);
            m_hold = 0; m_auto = bus.auto_en;
        end else if (m_auto != bus.auto_en) begin
            m_auto = bus.auto_en; m_hold = 0;
        end else if (m_auto && tick) begin
            m_hold++;
            if (m_hold == HT) begin
                m_src = nextv(m_src, bus.src_valid);
                m_hold = 0;
            end
        end
        show = m_urg || bus.src_valid[m_src];
        e_num = show ? bus.src_number[int'(m_src) * 16 +: 16] : 16'h0;
        e_dot = show ? bus.src_dot[int'(m_src) * 4 +: 4] : 4'h0;
        e_scan = (k % SD) == 0;
    endtask

    task automatic cycle();
        model_edge();
        @(posedge clk);
        #1;
        chk("number", 64'(bus.number), 64'(e_num));
        chk("dot", 64'(bus.dot), 64'(e_dot));
        chk("cur_src", 64'(bus.cur_src), 64'(m_src));
        chk("urgent_act", 64'(bus.urgent_act), 64'(m_urg));
        chk("scan_en", 64'(bus.scan_en), 64'(e_scan));
    endtask

    task automatic chk_zero(string tag);
        chk({tag, "_number"}, 64'(bus.number), 64'h0);
        chk({tag, "_dot"}, 64'(bus.dot), 64'h0);
        chk({tag, "_cur"}, 64'(bus.cur_src), 64'h0);
        chk({tag, "_act"}, 64'(bus.urgent_act), 64'h0);
        chk({tag, "_scan"}, 64'(bus.scan_en), 64'h0);
    endtask

    initial begin
        tbl[0]  = mk(4'hF, 1, 0, 4'h0, 11, 0, 16'h1111, 0);
        tbl[1]  = mk(4'hF, 1, 0, 4'h0,  1, 1, 16'h2222, 0);
        tbl[2]  = mk(4'hF, 1, 0, 4'h0, 12, 2, 16'h3333, 0);
        tbl[3]  = mk(4'hF, 1, 0, 4'h0, 12, 3, 16'h4444, 0);
        tbl[4]  = mk(4'hF, 1, 0, 4'h0, 12, 0, 16'h1111, 0);
        tbl[5]  = mk(4'h5, 1, 0, 4'h0, 12, 2, 16'h3333, 0);
        tbl[6]  = mk(4'h5, 1, 0, 4'h0, 12, 0, 16'h1111, 0);
        tbl[7]  = mk(4'h0, 1, 0, 4'h0, 12, 0, 16'h0000, 0);
        tbl[8]  = mk(4'hF, 0, 0, 4'h0, 24, 0, 16'h1111, 0);
        tbl[9]  = mk(4'hF, 0, 1, 4'h0, 20, 1, 16'h2222, 0);
        tbl[10] = mk(4'hF, 0, 0, 4'h0,  4, 1, 16'h2222, 0);
        tbl[11] = mk(4'hF, 0, 0, 4'hA,  1, 1, 16'h2222, 1);
        tbl[12] = mk(4'hF, 0, 0, 4'h0,  6, 1, 16'h2222, 1);
        tbl[13] = mk(4'hF, 0, 0, 4'h0,  1, 1, 16'h2222, 0);
        tbl[14] = mk(4'hF, 0, 0, 4'hC,  1, 2, 16'h3333, 1);
        tbl[15] = mk(4'hF, 0, 0, 4'h0,  7, 1, 16'h2222, 0);
        tbl[16] = mk(4'hF, 0, 1, 4'h0,  2, 1, 16'h2222, 0);
        tbl[17] = mk(4'hF, 0, 1, 4'h1,  1, 0, 16'h1111, 1);
        tbl[18] = mk(4'hF, 0, 0, 4'h0,  4, 0, 16'h1111, 1);
        tbl[19] = mk(4'hF, 0, 0, 4'h0,  1, 1, 16'h2222, 0);
        tbl[20] = mk(4'hF, 1, 0, 4'h0,  1, 1, 16'h2222, 0);
        tbl[21] = mk(4'hF, 1, 0, 4'h0, 11, 2, 16'h3333, 0);
        tbl[22] = mk(4'hB, 1, 0, 4'h0,  1, 2, 16'h0000, 0);
        tbl[23] = mk(4'hB, 1, 0, 4'h0, 11, 3, 16'h4444, 0);
        tbl[24] = mk(4'hF, 1, 0, 4'h0, 24, 1, 16'h2222, 0);

        bus.src_number = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
        bus.src_dot = {4'h8, 4'h4, 4'h2, 4'h1};
        bus.src_valid = 4'hF;
        bus.urgent = 4'h0;
        bus.auto_en = 1'b1;
        bus.btn_next = 1'b0;
        model_reset();

        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset");
        nrst = 1'b1;

        for (int i = 0; i < 25; i++) begin
            bus.src_valid = tbl[i].valid;
            bus.auto_en = tbl[i].auto_en;
            bus.btn_next = tbl[i].btn;
            bus.urgent = tbl[i].urg;
            for (int c = 0; c < tbl[i].n; c++) cycle();
            chk($sformatf("row%0d_cur", i), 64'(bus.cur_src), 64'(tbl[i].cur));
            chk($sformatf("row%0d_num", i), 64'(bus.number), 64'(tbl[i].num));
            chk($sformatf("row%0d_act", i), 64'(bus.urgent_act), 64'(tbl[i].act));
        end

        // asynchronous reset while source 1 is on display
        nrst = 1'b0;
        #1;
        chk_zero("midrst");
        repeat (2) @(posedge clk);
        #1;
        nrst = 1'b1;
        model_reset();
        cycle();
        chk("midrst_release_cur", 64'(bus.cur_src), 64'h0);
        chk("midrst_release_num", 64'(bus.number), 64'h1111);

        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 15) == 0)
                bus.src_valid = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 63) == 0)
                bus.auto_en = ~bus.auto_en;
            if ($urandom_range(0, 19) == 0)
                bus.btn_next = ~bus.btn_next;
            if ($urandom_range(0, 39) == 0)
                bus.urgent = 4'($urandom_range(1, 15));
            else if ($urandom_range(0, 3) == 0)
                bus.urgent = 4'h0;
            if ($urandom_range(0, 7) == 0)
                bus.src_number = {$urandom, $urandom};
            if ($urandom_range(0, 7) == 0)
                bus.src_dot = 16'($urandom);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
